// File: rtl/machine_control.sv
// Machine-mode trap/return sequencer: decodes ECALL/EBREAK/MRET, arbitrates
// interrupts over exceptions, and steers csr_file updates plus fetch PC/flush.
module machine_control (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       illegal_instr_in,
   input  logic       misaligned_instr_in,
   input  logic       misaligned_load_in,
   input  logic       misaligned_store_in,
   input  logic [4:0] opcode_6_to_2_in,
   input  logic [2:0] funct3_in,
   input  logic [6:0] funct7_in,
   input  logic [4:0] rs1_addr_in,
   input  logic [4:0] rs2_addr_in,
   input  logic [4:0] rd_addr_in,
   input  logic       mie_in,
   input  logic       meie_in,
   input  logic       mtie_in,
   input  logic       msie_in,
   input  logic       meip_in,
   input  logic       mtip_in,
   input  logic       msip_in,
   output logic       i_or_e_out,
   output logic [3:0] cause_out,
   output logic       set_cause_out,
   output logic       set_epc_out,
   output logic       mie_clear_out,
   output logic       mie_set_out,
   output logic       instret_inc_out,
   output logic       misaligned_exception_out,
   output logic [1:0] pc_src_out,
   output logic       flush_out
);
   typedef enum logic [1:0] {
      S_RESET       = 2'b00,
      S_OPERATING   = 2'b01,
      S_TRAP_TAKEN  = 2'b10,
      S_TRAP_RETURN = 2'b11
   } state_t;

   localparam logic [1:0] PC_BOOT = 2'b00;
   localparam logic [1:0] PC_EPC  = 2'b01;
   localparam logic [1:0] PC_TRAP = 2'b10;
   localparam logic [1:0] PC_NEXT = 2'b11;

   state_t r_state;

   logic       w_system, w_regs_zero, w_ecall, w_ebreak, w_mret;
   logic       w_ext, w_sw, w_tmr, w_irq, w_exc, w_trap;
   logic       w_intr;
   logic [3:0] w_cause;

   assign w_system    = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000);
   assign w_regs_zero = (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
   assign w_ecall  = w_system && w_regs_zero && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00000);
   assign w_ebreak = w_system && w_regs_zero && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00001);
   assign w_mret   = w_system && w_regs_zero && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);

   assign w_ext  = meie_in & meip_in;
   assign w_sw   = msie_in & msip_in;
   assign w_tmr  = mtie_in & mtip_in;
   assign w_irq  = mie_in & (w_ext | w_sw | w_tmr);
   assign w_exc  = misaligned_instr_in | illegal_instr_in | w_ecall | w_ebreak
                 | misaligned_load_in | misaligned_store_in;
   assign w_trap = w_irq | w_exc;

   // Interrupts pre-empt the faulting instruction; it re-executes from mepc.
   always_comb begin
      w_intr  = 1'b0;
      w_cause = 4'd0;
      if (w_irq) begin
         w_intr = 1'b1;
         if (w_ext)     w_cause = 4'd11;
         else if (w_sw) w_cause = 4'd3;
         else           w_cause = 4'd7;
      end else if (misaligned_instr_in) w_cause = 4'd0;
      else if (illegal_instr_in)        w_cause = 4'd2;
      else if (w_ebreak)                w_cause = 4'd3;
      else if (w_ecall)                 w_cause = 4'd11;
      else if (misaligned_load_in)      w_cause = 4'd4;
      else if (misaligned_store_in)     w_cause = 4'd6;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= S_RESET;
      end else begin
         case (r_state)
            S_OPERATING: begin
               if (w_trap)      r_state <= S_TRAP_TAKEN;
               else if (w_mret) r_state <= S_TRAP_RETURN;
            end
            default: r_state <= S_OPERATING;
         endcase
      end
   end

   always_comb begin
      i_or_e_out               = 1'b0;
      cause_out                = 4'd0;
      set_cause_out            = 1'b0;
      set_epc_out              = 1'b0;
      mie_clear_out            = 1'b0;
      mie_set_out              = 1'b0;
      instret_inc_out          = 1'b0;
      misaligned_exception_out = 1'b0;
      pc_src_out               = PC_BOOT;
      flush_out                = 1'b1;
      case (r_state)
         S_OPERATING: begin
            pc_src_out = PC_NEXT;
            flush_out  = 1'b0;
            if (w_trap) begin
               i_or_e_out               = w_intr;
               cause_out                = w_cause;
               set_cause_out            = 1'b1;
               set_epc_out              = 1'b1;
               mie_clear_out            = 1'b1;
               misaligned_exception_out = !w_intr &&
                  (w_cause == 4'd0 || w_cause == 4'd4 || w_cause == 4'd6);
            end else begin
               instret_inc_out = 1'b1;
               mie_set_out     = w_mret;
            end
         end
         S_TRAP_TAKEN:  pc_src_out = PC_TRAP;
         S_TRAP_RETURN: pc_src_out = PC_EPC;
         default:       pc_src_out = PC_BOOT;
      endcase
   end
endmodule

// File: doc/machine_control.md
Name: machine_control

Overview:
- Machine-mode trap/return controller for the RV32I core.
- Decodes ECALL/EBREAK/MRET, prioritises interrupts and exceptions, and sequences trap entry and return with a 4-state FSM.
- Directly upstream of csr_file: drives its set_cause/set_epc/cause/i_or_e/mie_clear/mie_set/instret_inc/misaligned_exception inputs and consumes its mie/enable/pending outputs.
- Selects the PC source and pipeline flush for fetch.

Parameters:
- none. State encodings and cause codes are fixed localparams.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-high
- illegal_instr_in  input  1  decoder flagged illegal instruction
- misaligned_instr_in  input  1  fetch target misaligned
- misaligned_load_in  input  1  load address misaligned
- misaligned_store_in  input  1  store address misaligned
- opcode_6_to_2_in  input  5  instruction[6:2]
- funct3_in  input  3  instruction[14:12]
- funct7_in  input  7  instruction[31:25]
- rs1_addr_in  input  5  instruction[19:15]
- rs2_addr_in  input  5  instruction[24:20]
- rd_addr_in  input  5  instruction[11:7]
- mie_in  input  1  mstatus.MIE
- meie_in, mtie_in, msie_in  input  1 each  interrupt enables
- meip_in, mtip_in, msip_in  input  1 each  interrupt pending
- i_or_e_out  output  1  1 = interrupt, 0 = exception
- cause_out  output  4  trap cause code
- set_cause_out  output  1  load mcause/mtval
- set_epc_out  output  1  load mepc from pc
- mie_clear_out  output  1  clear MIE, save to MPIE
- mie_set_out  output  1  restore MIE from MPIE
- instret_inc_out  output  1  instruction retired
- misaligned_exception_out  output  1  trap is a misaligned exception
- pc_src_out  output  2  00 boot, 01 epc, 10 trap address, 11 next pc
- flush_out  output  1  kill the in-flight instruction

Behaviour:
- FSM states:
  - RESET 00
  - OPERATING 01
  - TRAP_TAKEN 10
  - TRAP_RETURN 11
- State register is reset asynchronously to RESET. All other outputs are combinational from state and inputs.
- Decode: SYSTEM = opcode_6_to_2_in==11100 and funct3_in==000.
  - ECALL: SYSTEM, funct7=0, rs2=00000, rs1=0, rd=0.
  - EBREAK: same as ECALL but rs2=00001.
  - MRET: SYSTEM, funct7=0011000, rs2=00010, rs1=0, rd=0.
- Interrupt request: irq = mie_in & ((meie_in&meip_in)|(msie_in&msip_in)|(mtie_in&mtip_in)).
- Exception request: exc = misaligned_instr | illegal | ecall | ebreak | misaligned_load | misaligned_store.
- Cause priority, highest first:
  - external irq: 11, i_or_e=1
  - software irq: 3, i_or_e=1
  - timer irq: 7, i_or_e=1
  - instr misaligned: 0
  - illegal: 2
  - ebreak: 3
  - ecall: 11
  - load misaligned: 4
  - store misaligned: 6
  - Interrupts beat exceptions. A pre-empted faulting instruction re-executes after the handler because mepc = pc.
- RESET state:
  - pc_src=00, flush=1, all pulse outputs 0, cause_out=0, i_or_e=0.
  - Next state: OPERATING, unconditionally.
- OPERATING state, pc_src=11, flush=0:
  - irq|exc: set_cause=1, set_epc=1, mie_clear=1, instret_inc=0. cause/i_or_e per priority. misaligned_exception=1 only when the winning cause is 0, 4 or 6. Next state TRAP_TAKEN.
  - else MRET: mie_set=1, instret_inc=1. Next state TRAP_RETURN.
  - else: instret_inc=1. Stay in OPERATING.
- TRAP_TAKEN: pc_src=10, flush=1, all pulses 0. Next state OPERATING.
- TRAP_RETURN: pc_src=01, flush=1, all pulses 0. Next state OPERATING.
- Inputs are ignored in RESET, TRAP_TAKEN and TRAP_RETURN. Level-sensitive pending interrupts are therefore taken in the first following OPERATING cycle.
  - Because mie_clear fires on trap entry, no back-to-back interrupt occurs.
- Outside OPERATING-with-trap, cause_out=0 and i_or_e_out=0.
- Reset asserted mid-trap: state returns to RESET immediately (asynchronously). pc_src=00 and flush=1 while rst_in is high.
- No more than one of set_cause/mie_set is ever high in a cycle.

Test Plan:
- Reset release, no events -> cycle 0 in RESET: pc_src=00, flush=1. Then OPERATING with pc_src=11 and instret_inc=1 every cycle.
- ECALL word 0x00000073 in OPERATING -> set_cause=set_epc=mie_clear=1, cause=11, i_or_e=0. Next cycle pc_src=10, flush=1. Then back to OPERATING.
- MRET word 0x30200073 -> mie_set=1, instret_inc=1. Next cycle pc_src=01, flush=1.
- mie=1, meie=meip=1, mtie=mtip=1, illegal=1 in the same cycle -> cause=11, i_or_e=1, misaligned_exception=0. With mie=0: illegal wins, cause=2, i_or_e=0.
- misaligned_load=1 -> cause=4, misaligned_exception=1. misaligned_instr=1 together with misaligned_store=1 -> cause=0.
- rst_in asserted during TRAP_TAKEN -> pc_src=00 within the same cycle (asynchronous). After release: RESET then OPERATING. A held mtip with mtie=mie=1 traps with cause=7 on the first OPERATING cycle.
